cpu_fsm_param: RTL and testbench
================================

# cpu_fsm_param

Parametrised successor of the board's single-cycle-issue CPU controller. It owns its register file and ALU internally, takes one instruction per `send_pulse`, and executes it through a fixed multi-cycle FSM. The result goes to the LCD driver over a valid/ready handshake, so a slow display stalls the CPU instead of losing data. It sits between the button detectors / instruction switches and `displayLCD`.

## Interface
Parameters:
- `DATA_W`, 16: register and ALU width, two's complement; must be ≥ `IMM_W`+1.
- `REG_AW`, 4: register address width; there are 2^`REG_AW` registers.
- `IMM_W`, 6: immediate magnitude width; `IMM_W`+1 ≥ `REG_AW`.
- `INSTR_W` (derived, not overridable): 4 + 2·`REG_AW` + `IMM_W` + 1; 19 at defaults.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous reset, active-low.
- `pwr_pulse` in 1: one-cycle pulse from the power-button detector; toggles the system on/off.
- `send_pulse` in 1: one-cycle pulse from the send-button detector.
- `instr` in `INSTR_W`: instruction word, sampled only on an accepted send.
- `sys_on` out 1: the system is powered.
- `busy` out 1: high in every state except IDLE and OFF.
- `res_valid` out 1: a result is presented.
- `res_ready` in 1: the display accepts the result.
- `res_op` out 3: opcode of the presented result.
- `res_dest` out `REG_AW`: destination register of the presented result.
- `res_data` out `DATA_W`: value written to the destination register.
- `res_ovf` out 1: signed overflow flag; exists only with `CPU_OVF_FLAG_EN`.

## Operation
Instruction fields, MSB to LSB:
- `M` (1 bit), `op` (3), `dest` (`REG_AW`), `src1` (`REG_AW`), `opnd` (`IMM_W`+1).
- `M`=1: `opnd` is {sign, magnitude}. Operand B = sign ? −mag : +mag, sign-extended to `DATA_W`. A negative zero gives 0.
- `M`=0: B = reg[`opnd`[`REG_AW`-1:0]].
- A = reg[`src1`].

Opcodes:
- 000 LOAD: result = B. `src1` is ignored.
- 001 ADD: A+B.
- 010 SUB: A−B.
- 011 AND.
- 100 OR.
- 101 XOR.
- 110 SLT: result = 1 if A<B signed, else 0.
- 111 MUL: low `DATA_W` bits of the signed product.
- All results wrap modulo 2^`DATA_W`.

States:
- OFF: all outputs 0, registers untouched. On `pwr_pulse`, go to CLEAR.
- CLEAR: a counter writes 0 to one register per cycle, starting at address 0. After the last address, go to IDLE.
- IDLE: on `send_pulse`, latch `instr` and go to DECODE.
- DECODE: read A and B into operand registers.
- EXEC: ALU result (and overflow) into the result register.
- WB: write the result to reg[`dest`]; load `res_*`.
- DISP: `res_valid`=1. On `res_ready`, go to IDLE.

Boundary conditions:
- `pwr_pulse` in any non-OFF state: go to OFF next cycle. This aborts any operation, drops `res_valid` without a handshake, and leaves a WB in the same cycle uncommitted.
- `pwr_pulse` and `send_pulse` in the same cycle: power wins and the send is ignored.
- `send_pulse` while `busy` or OFF: ignored, not queued.
- `dest` equal to a source register: the sources are read in DECODE, so the old values are used.
- Register 0 is an ordinary register.

## Timing
- `rst` low at a `clk` edge: state OFF; `sys_on`, `busy`, `res_valid`, `res_op`, `res_dest`, `res_data`, `res_ovf` all 0; CLEAR counter 0.
- Power-on: `pwr_pulse` at edge t puts the block in CLEAR from t+1. CLEAR lasts 2^`REG_AW` cycles and IDLE is entered at t+1+2^`REG_AW`. `sys_on`=1 from t+1.
- Issue: `send_pulse` sampled in IDLE at edge t gives DECODE at t+1, EXEC at t+2, WB at t+3, and `res_valid`=1 from t+4.
- Minimum issue interval is 5 cycles with `res_ready` tied high.
- `res_*` stay stable while `res_valid`=1 and `res_ready`=0.
- Handshake completes on the edge where `res_valid`&`res_ready`. `res_valid` is 0 the next cycle, while `res_data` keeps its last value.
- `busy` is registered and equals (state ∉ {OFF, IDLE}).

## Configuration
- `CPU_OVF_FLAG_EN` defined: port `res_ovf` exists. It is set in EXEC for:
  - ADD/SUB signed overflow;
  - MUL whose full product is not the sign-extension of its low half.
  It is 0 for all other ops and is presented alongside `res_data`.
- `CPU_OVF_FLAG_EN` undefined: no `res_ovf` port, no overflow logic. Results wrap silently.

## Test plan
- Reset then power-on: `rst`=0 for 2 cycles, then `pwr_pulse` → `sys_on`=1 next cycle, `busy`=1 for exactly 16 cycles, then IDLE. Every register then reads 0.
- Immediate load: `M`=1, op=000, dest=3, sign=1, mag=5 → `res_valid` 4 cycles after send, `res_dest`=3, `res_data`=0xFFFB.
- Register-register: r1=7, r2=−3, then `M`=0, op=010 (SUB), dest=4, src1=1, src2=2 → `res_data`=10. A following SLT r2<r1 into r5 → 1.
- Backpressure: hold `res_ready`=0 for 10 cycles → `res_valid` and `res_data` stable. Pulse `send_pulse` during the stall → ignored. Raise `res_ready` → IDLE next cycle.
- Power-off mid-operation: `pwr_pulse` in EXEC → OFF next cycle, all outputs 0, destination register not written. Pulse `pwr_pulse` and `send_pulse` together in IDLE → OFF, no issue.
- With `CPU_OVF_FLAG_EN`: r1=0x7FFF, ADD immediate +1 → `res_data`=0x8000, `res_ovf`=1. MUL 0x0100×0x0100 → `res_data`=0, `res_ovf`=1.

Source files
------------

// File: rtl/cpu_fsm_param.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_fsm_param
//  Purpose  : Multi-cycle CPU controller with an internal register file and
//             ALU. Takes one instruction per send_pulse and runs it through
//             DECODE -> EXEC -> WB -> DISP. The result is handed to the
//             display over a valid/ready handshake.
//  Ports    : clk, rst (sync, active-low)
//             pwr_pulse  - toggles the system on/off (power-on clears regs)
//             send_pulse - issue request, honoured only in IDLE
//             instr      - {M, op[2:0], dest, src1, opnd[IMM_W:0]}
//             sys_on, busy
//             res_valid/res_ready handshake with res_op, res_dest, res_data
//             res_ovf    - signed overflow flag (only with CPU_OVF_FLAG_EN)
//  Options  : `define CPU_OVF_FLAG_EN adds the res_ovf port and its logic.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_fsm_param #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 6,
    localparam int INSTR_W = 4 + 2 * REG_AW + IMM_W + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwr_pulse,
    input  logic                send_pulse,
    input  logic [INSTR_W-1:0]  instr,
    output logic                sys_on,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2:0]          res_op,
    output logic [REG_AW-1:0]   res_dest,
    output logic [DATA_W-1:0]   res_data
`ifdef CPU_OVF_FLAG_EN
    ,
    output logic                res_ovf
`endif
);

    localparam int NREGS  = 1 << REG_AW;
    localparam int OPND_W = IMM_W + 1;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_SLT  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_CLEAR  = 3'd1,
        S_IDLE   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_DISP   = 3'd6
    } state_t;

    state_t              state;
    logic [REG_AW-1:0]   clr_cnt;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W-1:0]   result;

    // ------------------------------------------------------------------
    // Field extraction from the latched instruction
    // ------------------------------------------------------------------
    logic                f_m;
    logic [2:0]          f_op;
    logic [REG_AW-1:0]   f_dest;
    logic [REG_AW-1:0]   f_src1;
    logic [OPND_W-1:0]   f_opnd;

    assign f_m    = instr_q[INSTR_W-1];
    assign f_op   = instr_q[INSTR_W-2 -: 3];
    assign f_dest = instr_q[OPND_W + REG_AW +: REG_AW];
    assign f_src1 = instr_q[OPND_W +: REG_AW];
    assign f_opnd = instr_q[OPND_W-1:0];

    // Sign-magnitude immediate; negating a zero magnitude yields 0, so
    // "negative zero" needs no special case.
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   imm_val;
    logic [DATA_W-1:0]   a_val;
    logic [DATA_W-1:0]   b_val;

    assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, f_opnd[IMM_W-1:0]};
    assign imm_val = f_opnd[IMM_W] ? (DATA_W'(0) - imm_ext) : imm_ext;
    assign a_val   = regs[f_src1];
    assign b_val   = f_m ? imm_val : regs[f_opnd[REG_AW-1:0]];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   sum;
    logic [DATA_W-1:0]   diff;
    logic [DATA_W-1:0]   mul_lo;
    logic [DATA_W-1:0]   alu_res;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

`ifdef CPU_OVF_FLAG_EN
    // Full-width product of the sign-extended operands; its low 2*DATA_W
    // bits equal the signed product, so the upper half shows overflow.
    logic [2*DATA_W-1:0] prod_full;
    logic                ovf_q;
    logic                alu_ovf;

    assign prod_full = {{DATA_W{op_a[DATA_W-1]}}, op_a}
                     * {{DATA_W{op_b[DATA_W-1]}}, op_b};
    assign mul_lo    = prod_full[DATA_W-1:0];
`else
    // Low half of a product is the same for signed and unsigned operands.
    assign mul_lo    = op_a * op_b;
`endif

    always_comb begin
        alu_res = '0;
        case (f_op)
            OP_LOAD: alu_res = op_b;
            OP_ADD:  alu_res = sum;
            OP_SUB:  alu_res = diff;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_MUL:  alu_res = mul_lo;
            default: alu_res = '0;
        endcase
    end

`ifdef CPU_OVF_FLAG_EN
    always_comb begin
        alu_ovf = 1'b0;
        case (f_op)
            OP_ADD:  alu_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                               (sum[DATA_W-1]  != op_a[DATA_W-1]);
            OP_SUB:  alu_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                               (diff[DATA_W-1] != op_a[DATA_W-1]);
            OP_MUL:  alu_ovf = (prod_full[2*DATA_W-1:DATA_W] !=
                                {DATA_W{prod_full[DATA_W-1]}});
            default: alu_ovf = 1'b0;
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Register file: cleared one entry per cycle in CLEAR, written in WB.
    // A power pulse in the same cycle suppresses the write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst && !pwr_pulse) begin
            if (state == S_CLEAR) begin
                regs[clr_cnt] <= '0;
            end else if (state == S_WB) begin
                regs[f_dest] <= result;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_OFF;
            clr_cnt   <= '0;
            instr_q   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            sys_on    <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_op    <= '0;
            res_dest  <= '0;
            res_data  <= '0;
`ifdef CPU_OVF_FLAG_EN
            ovf_q     <= 1'b0;
            res_ovf   <= 1'b0;
`endif
        end else if (pwr_pulse && (state != S_OFF)) begin
            // Power-off aborts whatever is in flight, including a pending
            // result; it also beats a simultaneous send.
            state     <= S_OFF;
            clr_cnt   <= '0;
            sys_on    <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_op    <= '0;
            res_dest  <= '0;
            res_data  <= '0;
`ifdef CPU_OVF_FLAG_EN
            res_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_OFF: begin
                    if (pwr_pulse) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                        sys_on  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (send_pulse) begin
                        instr_q <= instr;
                        state   <= S_DECODE;
                        busy    <= 1'b1;
                    end
                end
                S_DECODE: begin
                    op_a  <= a_val;
                    op_b  <= b_val;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    result <= alu_res;
`ifdef CPU_OVF_FLAG_EN
                    ovf_q  <= alu_ovf;
`endif
                    state  <= S_WB;
                end
                S_WB: begin
                    res_op    <= f_op;
                    res_dest  <= f_dest;
                    res_data  <= result;
`ifdef CPU_OVF_FLAG_EN
                    res_ovf   <= ovf_q;
`endif
                    res_valid <= 1'b1;
                    state     <= S_DISP;
                end
                S_DISP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_OFF;
                    sys_on <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_fsm_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_fsm_param
//  Purpose  : Self-checking bench for cpu_fsm_param at default parameters.
//             Table of directed instructions with hand-computed results,
//             plus sequences for power-on, backpressure and power aborts.
//  Options  : honours CPU_OVF_FLAG_EN (checks res_ovf when defined).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_fsm_param;

    localparam int DATA_W  = 16;
    localparam int REG_AW  = 4;
    localparam int IMM_W   = 6;
    localparam int INSTR_W = 4 + 2 * REG_AW + IMM_W + 1;
    localparam int NVEC    = 30;

    logic               clk = 1'b0;
    logic               rst;
    logic               pwr_pulse;
    logic               send_pulse;
    logic [INSTR_W-1:0] instr;
    logic               sys_on;
    logic               busy;
    logic               res_valid;
    logic               res_ready;
    logic [2:0]         res_op;
    logic [REG_AW-1:0]  res_dest;
    logic [DATA_W-1:0]  res_data;
`ifdef CPU_OVF_FLAG_EN
    logic               res_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_fsm_param #(.DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwr_pulse  (pwr_pulse),
        .send_pulse (send_pulse),
        .instr      (instr),
        .sys_on     (sys_on),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_op     (res_op),
        .res_dest   (res_dest),
        .res_data   (res_data)
`ifdef CPU_OVF_FLAG_EN
        ,
        .res_ovf    (res_ovf)
`endif
    );

    typedef struct {
        logic        m;
        logic [2:0]  op;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [6:0]  opnd;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(sys_on && !busy) && n < 100) begin
            tick();
            n++;
        end
        check({nm, "_idle_reached"}, 32'(sys_on && !busy), 32'd1);
    endtask

    // Issue one instruction with res_ready high and check the exact timing.
    task automatic run_instr(input string nm, input logic m, input logic [2:0] op,
                             input logic [3:0] dest, input logic [3:0] src1,
                             input logic [6:0] opnd, input logic [15:0] exp_data,
                             input logic exp_ovf);
        instr      = {m, op, dest, src1, opnd};
        send_pulse = 1'b1;
        tick();
        send_pulse = 1'b0;
        check({nm, "_busy"}, 32'(busy), 32'd1);
        tick();
        tick();
        check({nm, "_valid_early"}, 32'(res_valid), 32'd0);
        tick();
        check({nm, "_valid"}, 32'(res_valid), 32'd1);
        check({nm, "_op"},    32'(res_op),    32'(op));
        check({nm, "_dest"},  32'(res_dest),  32'(dest));
        check({nm, "_data"},  32'(res_data),  32'(exp_data));
`ifdef CPU_OVF_FLAG_EN
        check({nm, "_ovf"},   32'(res_ovf),   32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unknown ovf expectation");
`endif
        tick();
        check({nm, "_valid_drop"}, 32'(res_valid), 32'd0);
        check({nm, "_busy_drop"},  32'(busy),      32'd0);
    endtask

    task automatic power_on(input string nm);
        int n = 0;
        pwr_pulse = 1'b1;
        tick();
        pwr_pulse = 1'b0;
        check({nm, "_sys_on"}, 32'(sys_on), 32'd1);
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check({nm, "_clear_cycles"}, 32'(n), 32'd16);
        check({nm, "_idle_busy"},    32'(busy), 32'd0);
    endtask

    // Read a register back via LOAD reg -> same reg (value unchanged).
    task automatic check_all_zero(input string nm);
        for (int r = 0; r < 16; r++) begin
            run_instr($sformatf("%s_r%0d", nm, r), 1'b0, 3'd0, 4'(r), 4'd0,
                      7'(r), 16'h0000, 1'b0);
        end
    endtask

    task automatic check_off(input string nm);
        check({nm, "_sys_on"},    32'(sys_on),    32'd0);
        check({nm, "_busy"},      32'(busy),      32'd0);
        check({nm, "_res_valid"}, 32'(res_valid), 32'd0);
        check({nm, "_res_op"},    32'(res_op),    32'd0);
        check({nm, "_res_dest"},  32'(res_dest),  32'd0);
        check({nm, "_res_data"},  32'(res_data),  32'd0);
`ifdef CPU_OVF_FLAG_EN
        check({nm, "_res_ovf"},   32'(res_ovf),   32'd0);
`endif
    endtask

    initial begin
        //           m     op    dest   src1   opnd    data      ovf
        vecs[0]  = '{1'b1, 3'd0, 4'd3,  4'd0,  7'h45, 16'hFFFB, 1'b0}; // LOAD r3=-5
        vecs[1]  = '{1'b1, 3'd0, 4'd1,  4'd0,  7'h07, 16'h0007, 1'b0}; // LOAD r1=7
        vecs[2]  = '{1'b1, 3'd0, 4'd2,  4'd0,  7'h43, 16'hFFFD, 1'b0}; // LOAD r2=-3
        vecs[3]  = '{1'b0, 3'd2, 4'd4,  4'd1,  7'h02, 16'h000A, 1'b0}; // SUB r1-r2
        vecs[4]  = '{1'b0, 3'd6, 4'd5,  4'd2,  7'h01, 16'h0001, 1'b0}; // SLT r2<r1
        vecs[5]  = '{1'b1, 3'd1, 4'd6,  4'd1,  7'h7F, 16'hFFC8, 1'b0}; // ADD 7+(-63)
        vecs[6]  = '{1'b0, 3'd3, 4'd7,  4'd3,  7'h01, 16'h0003, 1'b0}; // AND
        vecs[7]  = '{1'b0, 3'd4, 4'd8,  4'd4,  7'h02, 16'hFFFF, 1'b0}; // OR
        vecs[8]  = '{1'b0, 3'd5, 4'd9,  4'd3,  7'h02, 16'h0006, 1'b0}; // XOR
        vecs[9]  = '{1'b0, 3'd7, 4'd10, 4'd2,  7'h01, 16'hFFEB, 1'b0}; // MUL -3*7
        vecs[10] = '{1'b1, 3'd0, 4'd11, 4'd0,  7'h40, 16'h0000, 1'b0}; // negative zero
        vecs[11] = '{1'b0, 3'd1, 4'd1,  4'd1,  7'h01, 16'h000E, 1'b0}; // r1=r1+r1
        vecs[12] = '{1'b1, 3'd6, 4'd12, 4'd1,  7'h14, 16'h0001, 1'b0}; // SLT 14<20
        vecs[13] = '{1'b1, 3'd2, 4'd13, 4'd0,  7'h01, 16'hFFFF, 1'b0}; // r0-1
        vecs[14] = '{1'b1, 3'd0, 4'd0,  4'd0,  7'h05, 16'h0005, 1'b0}; // LOAD r0=5
        vecs[15] = '{1'b0, 3'd1, 4'd14, 4'd0,  7'h00, 16'h000A, 1'b0}; // r0+r0
        vecs[16] = '{1'b0, 3'd7, 4'd15, 4'd3,  7'h03, 16'h0019, 1'b0}; // -5*-5
        vecs[17] = '{1'b0, 3'd6, 4'd12, 4'd3,  7'h01, 16'h0001, 1'b0}; // SLT -5<14
        vecs[18] = '{1'b1, 3'd0, 4'd1,  4'd0,  7'h10, 16'h0010, 1'b0}; // LOAD r1=16
        vecs[19] = '{1'b0, 3'd7, 4'd2,  4'd1,  7'h01, 16'h0100, 1'b0}; // 16*16
        vecs[20] = '{1'b0, 3'd7, 4'd3,  4'd2,  7'h02, 16'h0000, 1'b1}; // 0x100*0x100
        vecs[21] = '{1'b1, 3'd0, 4'd4,  4'd0,  7'h41, 16'hFFFF, 1'b0}; // LOAD r4=-1
        vecs[22] = '{1'b1, 3'd7, 4'd5,  4'd1,  7'h08, 16'h0080, 1'b0}; // 16*8
        vecs[23] = '{1'b0, 3'd7, 4'd6,  4'd2,  7'h05, 16'h8000, 1'b1}; // 0x100*0x80
        vecs[24] = '{1'b0, 3'd5, 4'd7,  4'd6,  7'h04, 16'h7FFF, 1'b0}; // XOR -> 7FFF
        vecs[25] = '{1'b1, 3'd1, 4'd8,  4'd7,  7'h01, 16'h8000, 1'b1}; // 7FFF+1
        vecs[26] = '{1'b1, 3'd2, 4'd9,  4'd6,  7'h01, 16'h7FFF, 1'b1}; // 8000-1
        vecs[27] = '{1'b0, 3'd7, 4'd13, 4'd4,  7'h04, 16'h0001, 1'b0}; // -1*-1
        vecs[28] = '{1'b0, 3'd2, 4'd11, 4'd7,  7'h04, 16'h8000, 1'b1}; // 7FFF-(-1)
        vecs[29] = '{1'b0, 3'd1, 4'd12, 4'd4,  7'h04, 16'hFFFE, 1'b0}; // -1+-1

        rst        = 1'b0;
        pwr_pulse  = 1'b0;
        send_pulse = 1'b0;
        instr      = '0;
        res_ready  = 1'b1;
        tick();
        tick();
        check_off("reset");
        rst = 1'b1;
        tick();

        // Power-on and first clear
        power_on("pwr1");
        check_all_zero("clr1");

        // Directed instruction table
        for (int i = 0; i < NVEC; i++) begin
            run_instr($sformatf("v%0d", i), vecs[i].m, vecs[i].op, vecs[i].dest,
                      vecs[i].src1, vecs[i].opnd, vecs[i].exp_data, vecs[i].exp_ovf);
        end

        // Backpressure: LOAD r3=9 held for 10 cycles; a send in the stall
        // (LOAD r10=33) must be dropped.
        res_ready  = 1'b0;
        instr      = {1'b1, 3'd0, 4'd3, 4'd0, 7'h09};
        send_pulse = 1'b1;
        tick();
        send_pulse = 1'b0;
        tick();
        tick();
        tick();
        check("bp_valid", 32'(res_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                instr      = {1'b1, 3'd0, 4'd10, 4'd0, 7'h21};
                send_pulse = 1'b1;
            end
            tick();
            send_pulse = 1'b0;
            check($sformatf("bp_hold%0d_valid", c), 32'(res_valid), 32'd1);
            check($sformatf("bp_hold%0d_data", c),  32'(res_data),  32'h0009);
            check($sformatf("bp_hold%0d_dest", c),  32'(res_dest),  32'd3);
        end
        res_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(res_valid), 32'd0);
        check("bp_release_busy",  32'(busy),      32'd0);
        check("bp_keep_data",     32'(res_data),  32'h0009);
        run_instr("bp_r10", 1'b0, 3'd0, 4'd10, 4'd0, 7'h0A, 16'hFFEB, 1'b0);

        // Power-off in EXEC: LOAD r14=44 must not commit (r14 holds 10)
        instr      = {1'b1, 3'd0, 4'd14, 4'd0, 7'h2C};
        send_pulse = 1'b1;
        tick();
        send_pulse = 1'b0;
        tick();
        pwr_pulse = 1'b1;
        tick();
        pwr_pulse = 1'b0;
        check_off("abort_exec");
        tick();
        tick();
        check("abort_exec_r14", 32'(dut.regs[14]), 32'h000A);

        // Send while OFF is ignored
        send_pulse = 1'b1;
        tick();
        send_pulse = 1'b0;
        tick();
        check("off_send_sys_on", 32'(sys_on), 32'd0);
        check("off_send_busy",   32'(busy),   32'd0);

        // Second power-on clears dirty registers
        power_on("pwr2");
        check_all_zero("clr2");

        // Power-off during WB leaves the write uncommitted
        run_instr("wb_pre", 1'b1, 3'd0, 4'd2, 4'd0, 7'h09, 16'h0009, 1'b0);
        instr      = {1'b1, 3'd0, 4'd2, 4'd0, 7'h15};
        send_pulse = 1'b1;
        tick();
        send_pulse = 1'b0;
        tick();
        tick();
        pwr_pulse = 1'b1;
        tick();
        pwr_pulse = 1'b0;
        check_off("abort_wb");
        tick();
        check("abort_wb_r2", 32'(dut.regs[2]), 32'h0009);

        // Power and send together in IDLE: power wins, no issue
        power_on("pwr3");
        wait_idle("pwr3");
        instr      = {1'b1, 3'd0, 4'd1, 4'd0, 7'h01};
        pwr_pulse  = 1'b1;
        send_pulse = 1'b1;
        tick();
        pwr_pulse  = 1'b0;
        send_pulse = 1'b0;
        check_off("pwr_send");
        tick();
        tick();
        check_off("pwr_send_later");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
